// File: rtl/buf_word_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : buf_word_packer
// Purpose  : Pops IN_W-bit entries from a pulse-read FIFO and packs BEATS of
//            them into one OUT_W-bit word offered on a valid/ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module buf_word_packer #(
   parameter int IN_W      = 16,
   parameter int OUT_W     = 64,
   parameter int MSB_FIRST = 0,
   localparam int BEATS    = OUT_W / IN_W,
   localparam int BCW      = $clog2(BEATS) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             buf_avail,
   input  logic [IN_W-1:0]  buf_dout,
   output logic             buf_re,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [BCW-1:0]   beat_cnt,
   output logic [15:0]      words_out
);

   typedef enum logic [1:0] {
      S_REQ = 2'd0,
      S_CAP = 2'd1,
      S_OUT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             buf_re_q, buf_re_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic [BCW-1:0]   beat_q, beat_d;
   logic [15:0]      words_q, words_d;

   always_comb begin
      state_d     = state_q;
      buf_re_d    = buf_re_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      beat_d      = beat_q;
      words_d     = words_q;
      if (flush) begin
         // Flush wins over a same-cycle handshake; a popped entry in CAP is dropped.
         state_d     = S_REQ;
         buf_re_d    = 1'b0;
         out_valid_d = 1'b0;
         beat_d      = '0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (buf_avail) begin
                  buf_re_d = 1'b1;
                  state_d  = S_CAP;
               end
            end
            S_CAP: begin
               for (int i = 0; i < BEATS; i++) begin
                  if (beat_q == BCW'(i)) begin
                     data_d[((MSB_FIRST != 0) ? (BEATS - 1 - i) : i) * IN_W +: IN_W] = buf_dout;
                  end
               end
               buf_re_d = 1'b0;
               beat_d   = beat_q + 1'b1;
               if (beat_q == BCW'(BEATS - 1)) begin
                  out_valid_d = 1'b1;
                  state_d     = S_OUT;
               end else begin
                  state_d = S_REQ;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  beat_d      = '0;
                  words_d     = words_q + 16'd1;
                  state_d     = S_REQ;
               end
            end
            default: begin
               state_d     = S_REQ;
               buf_re_d    = 1'b0;
               out_valid_d = 1'b0;
               beat_d      = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_REQ;
         buf_re_q    <= 1'b0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         beat_q      <= '0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         buf_re_q    <= buf_re_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         beat_q      <= beat_d;
         words_q     <= words_d;
      end
   end

   assign buf_re    = buf_re_q;
   assign out_valid = out_valid_q;
   assign out_data  = data_q;
   assign beat_cnt  = beat_q;
   assign words_out = words_q;

endmodule
`default_nettype wire
